// File: rtl/debounce_meas_ctrl.sv
// debounce_meas_ctrl: clears the edge counters, times a tick window, then captures raw/debounced/bounce counts behind valid/ready.
module debounce_meas_ctrl #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIN_W-1:0] i_win_len,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_lvl_count,
  input  logic [CNT_W-1:0] i_lvl_db_count,
  output logic             o_clr,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_raw_count,
  output logic [CNT_W-1:0] o_db_count,
  output logic [CNT_W-1:0] o_bounce_count,
  output logic             o_sat
);
  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, WINDOW, CAPTURE, HOLD} state_t;
  localparam logic [CNT_W-1:0] ONES = '1;
  state_t state_q, state_d;
  logic [WIN_W-1:0] win_q;
  logic sticky_q;
  logic accept, tick_en, cap_en;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_start ? CLEAR : IDLE;
      CLEAR:   state_d = SETTLE;
      SETTLE:  state_d = WINDOW;
      WINDOW:  state_d = (i_tick && win_q == WIN_W'(1)) ? CAPTURE : WINDOW;
      CAPTURE: state_d = HOLD;
      HOLD:    state_d = i_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
    if (i_abort) state_d = IDLE;
  end
  assign accept  = state_q == IDLE && state_d == CLEAR;
  assign tick_en = state_q == WINDOW && i_tick && !i_abort;
  assign cap_en  = state_q == CAPTURE && !i_abort;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      win_q          <= '0;
      sticky_q       <= 1'b0;
      o_raw_count    <= '0;
      o_db_count     <= '0;
      o_bounce_count <= '0;
      o_sat          <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= accept ? ((i_win_len == '0) ? WIN_W'(1) : i_win_len) : tick_en ? win_q - 1'b1 : win_q;
      sticky_q <= (state_q == CLEAR) ? 1'b0 : (state_q == WINDOW && i_lvl_count == ONES) ? 1'b1 : sticky_q;
      // Results move only on a non-aborted capture so an abort leaves the last measurement visible
      if (cap_en) begin
        o_raw_count    <= i_lvl_count;
        o_db_count     <= i_lvl_db_count;
        o_bounce_count <= (i_lvl_count >= i_lvl_db_count) ? i_lvl_count - i_lvl_db_count : '0;
        o_sat          <= sticky_q || i_lvl_count == ONES;
      end
    end
  end
  assign o_clr   = state_q == CLEAR;
  assign o_busy  = state_q != IDLE;
  assign o_valid = state_q == HOLD;
endmodule

// File: tb/tb_debounce_meas_ctrl.sv
// tb_debounce_meas_ctrl: randomized measurements against a count-level model, results checked by a handshake monitor.
module tb_debounce_meas_ctrl;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_abort = 1'b0, i_tick = 1'b0, i_ready = 1'b1;
  logic [15:0] i_win_len = '0;
  logic [7:0]  i_lvl_count = '0, i_lvl_db_count = '0;
  logic        o_clr, o_busy, o_valid, o_sat;
  logic [7:0]  o_raw_count, o_db_count, o_bounce_count;
  typedef struct packed {logic [7:0] raw; logic [7:0] db; logic [7:0] bounce; logic sat;} res_t;
  res_t exp_q[$];
  res_t prev = '0;
  res_t mon_e;
  int checks = 0, errors = 0;
  bit sat_seen = 0;

  debounce_meas_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_win_len(i_win_len), .i_tick(i_tick), .i_lvl_count(i_lvl_count),
    .i_lvl_db_count(i_lvl_db_count), .o_clr(o_clr), .o_busy(o_busy),
    .o_valid(o_valid), .i_ready(i_ready), .o_raw_count(o_raw_count),
    .o_db_count(o_db_count), .o_bounce_count(o_bounce_count), .o_sat(o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic res_t cur_res();
    return {o_raw_count, o_db_count, o_bounce_count, o_sat};
  endfunction

  // Datapath stand-in: counts only grow during the window, toward fixed targets or at random
  task automatic window_cycle(input int raw_tgt, input int db_tgt);
    if (raw_tgt >= 0) begin
      if (int'(i_lvl_count) < raw_tgt) i_lvl_count = i_lvl_count + 8'd1;
      if (int'(i_lvl_db_count) < db_tgt) i_lvl_db_count = i_lvl_db_count + 8'd1;
    end else begin
      if ($urandom_range(0, 2) == 0 && i_lvl_count < 8'd240) i_lvl_count = i_lvl_count + 8'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0 && i_lvl_db_count < 8'd240) i_lvl_db_count = i_lvl_db_count + 8'd1;
    end
    if (i_lvl_count == 8'hFF) sat_seen = 1;
  endtask

  task automatic measure(input logic [15:0] wl, input int gap, input int raw_tgt, input int db_tgt,
                         input int abort_at, input int ready_wait, input bit force_sat);
    int eff = (wl == 16'd0) ? 1 : int'(wl);
    res_t e, hold_v;
    i_ready = (ready_wait == 0);
    i_win_len = wl;
    i_start = 1'b1;
    i_lvl_count = '0;
    i_lvl_db_count = '0;
    sat_seen = 0;
    step();
    i_start = 1'b0;
    chk("clr_in_clear", {31'd0, o_clr}, 1);
    chk("busy_after_start", {31'd0, o_busy}, 1);
    step();
    chk("clr_one_cycle", {31'd0, o_clr}, 0);
    step();
    for (int t = 1; t <= eff; t++) begin
      int g = (gap > 0) ? gap : int'($urandom_range(1, 6));
      for (int c = 0; c < g - 1; c++) begin
        if (force_sat && t == 1 && c == 1) begin
          i_lvl_count = 8'hFF;
          sat_seen = 1;
        end else if (force_sat && t == 1 && c == 2) i_lvl_count = 8'd3;
        else window_cycle(raw_tgt, db_tgt);
        step();
        chk("no_valid_in_window", {31'd0, o_valid}, 0);
      end
      window_cycle(raw_tgt, db_tgt);
      i_tick = 1'b1;
      if (t == eff) begin
        e.raw = i_lvl_count;
        e.db = i_lvl_db_count;
        e.bounce = (i_lvl_count >= i_lvl_db_count) ? i_lvl_count - i_lvl_db_count : 8'd0;
        e.sat = sat_seen || i_lvl_count == 8'hFF;
        exp_q.push_back(e);
        prev = e;
      end
      step();
      i_tick = 1'b0;
      if (t == abort_at) begin
        i_abort = 1'b1;
        i_tick = 1'b1;
        step();
        i_abort = 1'b0;
        i_tick = 1'b0;
        chk("abort_busy", {31'd0, o_busy}, 0);
        chk("abort_valid", {31'd0, o_valid}, 0);
        chk("abort_keep_result", 32'(cur_res()), 32'(prev));
        repeat (3) begin
          step();
          chk("abort_no_clr", {30'd0, o_clr, o_busy}, 0);
        end
        return;
      end
    end
    chk("capture_not_valid", {30'd0, o_valid, o_busy}, 32'd1);
    step();
    chk("hold_valid", {31'd0, o_valid}, 1);
    if (ready_wait > 0) begin
      hold_v = cur_res();
      for (int c = 0; c < ready_wait; c++) begin
        i_start = (c == 3);
        step();
        chk("hold_stable", {6'd0, o_valid, 32'(cur_res())}, {7'd1, 32'(hold_v)});
      end
      i_start = 1'b0;
      i_ready = 1'b1;
    end
    step();
    chk("idle_after_handshake", {30'd0, o_busy, o_valid}, 0);
    step();
    chk("no_queued_start", {30'd0, o_busy, o_clr}, 0);
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", cur_res());
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", 32'(cur_res()), 32'(mon_e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_outputs", {6'd0, o_clr, o_busy, o_valid, 32'(cur_res())}, 0);
    i_rst_n = 1'b1;
    step();
    measure(16'd4, 10, 7, 1, 0, 0, 0);
    measure(16'd4, 10, 7, 1, 0, 20, 0);
    measure(16'd4, 0, -1, -1, 2, 0, 0);
    measure(16'd0, 0, -1, -1, 0, 0, 0);
    measure(16'd1, 0, -1, -1, 0, 0, 0);
    measure(16'd3, 5, -1, -1, 0, 0, 1);
    measure(16'd2, 6, 2, 5, 0, 0, 0);
    i_win_len = 16'd5;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (5) begin
      window_cycle(-1, -1);
      step();
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {6'd0, o_clr, o_busy, o_valid, 32'(cur_res())}, 0);
    prev = '0;
    step();
    step();
    i_rst_n = 1'b1;
    measure(16'd3, 0, -1, -1, 0, 0, 0);
    for (int n = 0; n < 25; n++) begin
      logic [15:0] wl = 16'($urandom_range(0, 5));
      int eff = (wl == 16'd0) ? 1 : int'(wl);
      int ab = ($urandom_range(0, 5) == 0 && eff > 1) ? int'($urandom_range(1, eff - 1)) : 0;
      int rw = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 5));
      measure(wl, 0, -1, -1, ab, rw, $urandom_range(0, 3) == 0 && eff > 1);
    end
    step();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/debounce_meas_ctrl.md
# debounce_meas_ctrl

Measurement sequencer for the switch debounce-counting datapath. It clears the raw and debounced edge counters and opens a measurement window of a programmed number of slow ticks. At the end of the window it captures both counts, computes the bounce count, and presents the result on a valid/ready handshake. It sits between the debounce counter and the display/UART reporting logic, and owns the counters' clear line.

## Interface

- CNT_W, default 8: width of the raw and debounced counter values.
- WIN_W, default 16: width of the window-length input, in slow ticks.

- i_clk, in, 1: system clock; all logic on the rising edge.
- i_rst_n, in, 1: reset, asynchronous and active-low.
- i_start, in, 1: start request; sampled only in IDLE.
- i_abort, in, 1: abandon the measurement; highest priority.
- i_win_len, in, WIN_W: window length in ticks; sampled on the accepted start.
- i_tick, in, 1: slow-tick enable; counted only in WINDOW.
- i_lvl_count, in, CNT_W: raw edge count from the datapath.
- i_lvl_db_count, in, CNT_W: debounced edge count from the datapath.
- o_clr, out, 1: counter clear, drives the datapath clear input.
- o_busy, out, 1: high in every state except IDLE.
- o_valid, out, 1: result valid.
- i_ready, in, 1: result consumer ready.
- o_raw_count, out, CNT_W: captured raw count.
- o_db_count, out, CNT_W: captured debounced count.
- o_bounce_count, out, CNT_W: raw minus debounced, floored at 0.
- o_sat, out, 1: raw count hit its all-ones value during the window.

## Operation

- States: IDLE, CLEAR, SETTLE, WINDOW, CAPTURE, HOLD. Outputs are Moore, decoded from the registered state.
- IDLE:
  - o_busy = 0.
  - i_start = 1 → CLEAR. The window register loads i_win_len; a value of 0 is loaded as 1.
- CLEAR:
  - o_clr = 1 for exactly this one cycle.
  - The sticky saturation flag is cleared.
  - → SETTLE.
- SETTLE: one cycle in which the counters read 0 → WINDOW.
- WINDOW:
  - Each i_tick decrements the remaining-tick register.
  - i_tick with remaining == 1 → CAPTURE.
  - Sticky flag sets whenever i_lvl_count == 2^CNT_W−1.
- CAPTURE:
  - Load o_raw_count and o_db_count from the inputs.
  - Load o_bounce_count = (raw ≥ db) ? raw − db : 0, computed at CNT_W bits with no wrap.
  - Load o_sat = sticky flag OR (the captured raw value == all-ones).
  - → HOLD.
- HOLD:
  - o_valid = 1. All result outputs are stable.
  - o_valid & i_ready → IDLE.
- i_abort:
  - In any non-IDLE state → IDLE on the next edge.
  - No capture; result registers keep their previous values; o_valid falls.
  - Overrides i_start, i_tick and i_ready in the same cycle.
- i_start outside IDLE is ignored; no queuing.
- i_tick outside WINDOW is ignored.
- Result registers change only in CAPTURE.

## Timing

- Reset (i_rst_n = 0): immediately forces IDLE and sets every output to 0 (o_clr, o_busy, o_valid, all counts, o_sat). The window and sticky registers also go to 0. A reset mid-measurement discards the measurement.
- Release of reset: first start accepted on the first rising edge with i_rst_n = 1 and i_start = 1.
- Start accepted at edge E0:
  - o_busy = 1 and o_clr = 1 in cycle E0→E1.
  - SETTLE in E1→E2.
  - WINDOW from E2.
- Final tick sampled at edge Ek:
  - CAPTURE during Ek→Ek+1.
  - o_valid = 1 from Ek+1.
- Handshake:
  - With i_ready held high, o_valid lasts one cycle and o_busy falls at the same edge.
  - Minimum start-to-start period with i_ready high: 5 cycles + tick wait.
- Captured counts include every counter update registered up to the final tick's edge.

## Test plan

- i_win_len = 4, i_tick every 10 cycles, 7 raw / 1 debounced edges driven in window → o_clr high exactly 1 cycle after start; o_valid with raw = 7, db = 1, bounce = 6, sat = 0, one cycle after the 4th tick's CAPTURE.
- Same as above with i_ready low for 20 cycles → o_valid and all counts stable for all 20 cycles; o_busy and o_valid fall on the edge after i_ready = 1; a start pulsed during HOLD is ignored.
- i_abort after 2 of 4 ticks → IDLE next edge; o_valid never asserts; result outputs keep the prior measurement values; o_clr not reasserted.
- i_win_len = 0 → CAPTURE after the first tick, identical to i_win_len = 1.
- i_lvl_count driven to 255 mid-window then 3 → o_sat = 1. Separately, raw = 2, db = 5 → o_bounce_count = 0.
- i_rst_n pulsed low during WINDOW → all outputs 0 asynchronously, before the next clock edge. After release, a new start runs a full CLEAR/SETTLE/WINDOW sequence.
